// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/response bundle for the iterative shift sequencer
//
// Purpose: groups the request handshake, operands, flush, response handshake,
// result and busy flag of shift_sequencer into one port.
// Ports (signals):
//   req_valid/req_ready    request handshake (requester -> sequencer)
//   Operation, SrcA, SrcB  ALU code, value to shift, shift amount
//   flush                  abort the operation in flight
//   resp_valid/resp_ready  response handshake (sequencer -> consumer)
//   Rd, resp_err           result and "not a shift code" flag
//   busy                   sequencer is in SHIFT or DONE
// Modports: master = requester/consumer side, slave = sequencer side.
interface shift_sequencer_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic                     flush;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [DATA_WIDTH-1:0]    Rd;
    logic                     resp_err;
    logic                     busy;

    modport master (
        output req_valid, Operation, SrcA, SrcB, flush, resp_ready,
        input  req_ready, resp_valid, Rd, resp_err, busy
    );

    modport slave (
        input  req_valid, Operation, SrcA, SrcB, flush, resp_ready,
        output req_ready, resp_valid, Rd, resp_err, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle SLL/SRL/SRA controller shifting STEP bits per cycle
//
// Purpose: accepts one shift request, shifts the latched operand by at most
// STEP bits per cycle, then presents the result until the consumer takes it.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high
//   bus    slave modport of shift_sequencer_if (handshakes, operands, result)
module shift_sequencer #(
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       OPCODE_LENGTH = 4,
    parameter int                       STEP          = 1,
    parameter logic [OPCODE_LENGTH-1:0] OP_SLL        = 4'b1001,
    parameter logic [OPCODE_LENGTH-1:0] OP_SRL        = 4'b1010,
    parameter logic [OPCODE_LENGTH-1:0] OP_SRA        = 4'b1011
) (
    input  logic              clk,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);
    localparam int SW = $clog2(DATA_WIDTH);
    // One extra bit so STEP == DATA_WIDTH is representable in the min() compare.
    localparam logic [SW:0] STEP_K = STEP[SW:0];

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    rd_q, rd_d;
    logic [SW-1:0]            rem_q, rem_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic                     err_q, err_d;

    logic [SW-1:0]            shamt;
    logic [SW:0]              k;
    logic [SW:0]              rem_left;
    logic [DATA_WIDTH-1:0]    shifted;
    logic                     unused_srcb_hi;

    function automatic logic is_shift(input logic [OPCODE_LENGTH-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    assign shamt          = bus.SrcB[SW-1:0];
    assign unused_srcb_hi = ^bus.SrcB[DATA_WIDTH-1:SW];

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        rem_d    = rem_q;
        op_d     = op_q;
        err_d    = err_q;

        // k = min(STEP, remaining); the final partial step never overshoots.
        k = STEP_K;
        if ({1'b0, rem_q} < STEP_K) begin
            k = {1'b0, rem_q};
        end
        rem_left = {1'b0, rem_q} - k;

        shifted = rd_q;
        case (op_q)
            OP_SLL:  shifted = rd_q << k;
            OP_SRL:  shifted = rd_q >> k;
            OP_SRA:  shifted = $signed(rd_q) >>> k;
            default: shifted = rd_q;
        endcase

        if (bus.flush) begin
            // Partial result is abandoned; Rd simply keeps whatever it holds.
            state_d = IDLE;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_d  = bus.Operation;
                        rd_d  = bus.SrcA;
                        rem_d = shamt;
                        err_d = 1'b0;
                        if (!is_shift(bus.Operation)) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else if (shamt == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    rd_d  = shifted;
                    rem_d = rem_left[SW-1:0];
                    if (rem_left == '0) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rd_q    <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE) & ~bus.flush;
    assign bus.resp_valid = (state_q == DONE);
    assign bus.Rd         = rd_q;
    assign bus.resp_err   = err_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
